decode_stage: RTL and testbench

Instruction-decode and operand-fetch stage of the multi-cycle RV32I core. It accepts a fetched instruction and its PC, latches them into an instruction register, and drives rs1/rs2/rd to the register file. It captures the register-file read data into operand registers one cycle later, then holds the decoded bundle (fields, immediate, operands, PC) under a valid/ready handshake for the execute stage.

---
 rtl/decode_stage.sv | 243 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Instruction-decode and operand-fetch stage of the multi-cycle RV32I core.
// An accepted instruction is latched into the instruction register (IR)
// together with its PC. rs1/rs2/rd are driven to the register file straight
// from the IR. The register-file read data is captured into the operand
// registers at the edge that closes READ. The decoded bundle is then held
// under a valid/ready handshake until the execute stage takes it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     fetch-side handshake (ready only in IDLE)
//   instr, pc             fetched instruction word and its address
//   flush                 synchronous abort, highest priority
//   rs1, rs2, rd          register-file addresses (combinational from IR)
//   rs1v, rs2v            combinational register-file read data
//   dec_valid/ready       execute-side handshake (valid only in HOLD)
//   opcode/funct3/funct7  raw IR fields
//   imm                   sign-extended immediate for the IR's format
//   a_val, b_val          latched operands
//   pc_q                  latched PC
//   illegal               unsupported opcode or IR[1:0] != 2'b11
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013  // ADDI x0,x0,0
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch side
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        flush,
  // register file
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  input  logic [31:0] rs1v,
  input  logic [31:0] rs2v,
  // execute side
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [31:0] a_val,
  output logic [31:0] b_val,
  output logic [31:0] pc_q,
  output logic        illegal
);

  // -------------------------------------------------------------------------
  // Types and constants
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Immediate formats; FMT_BAD covers every encoding we do not support.
  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_BAD
  } fmt_e;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        ir_load;   // capture instr/pc this edge
  logic        op_load;   // capture rs1v/rs2v this edge

  logic [31:0] ir_q,    ir_d;
  logic [31:0] pc_d;
  logic [31:0] a_val_q, a_val_d;
  logic [31:0] b_val_q, b_val_d;

  fmt_e        fmt;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default at the top of the block;
  // a path that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_READ;
      ST_READ: state_d = ST_HOLD;
      ST_HOLD: if (dec_ready)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // flush overrides everything; with dec_ready also high in HOLD the
    // result is the same IDLE, so the bundle simply counts as consumed.
    if (flush) state_d = ST_IDLE;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    instr_ready = 1'b0;
    dec_valid   = 1'b0;
    ir_load     = 1'b0;
    op_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        ir_load     = instr_valid && !flush;
      end
      ST_READ: begin
        op_load     = !flush;
      end
      ST_HOLD: begin
        dec_valid   = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state: IR/PC load in IDLE, operands load at end of READ;
  // everything else (including HOLD and any flushed edge) holds its value.
  // -------------------------------------------------------------------------
  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    a_val_d = a_val_q;
    b_val_d = b_val_q;
    if (ir_load) begin
      ir_d = instr;
      pc_d = pc;
    end
    if (op_load) begin
      a_val_d = rs1v;
      b_val_d = rs2v;
    end
  end

  // The reset values of IR, PC and operands are visible on the outputs, so
  // all of them are reset along with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q    <= RESET_INSTR;
      pc_q    <= '0;
      a_val_q <= '0;
      b_val_q <= '0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      a_val_q <= a_val_d;
      b_val_q <= b_val_d;
    end
  end

  assign a_val = a_val_q;
  assign b_val = b_val_q;

  // -------------------------------------------------------------------------
  // Field extraction (pure wiring from the IR, so stable through READ/HOLD)
  // -------------------------------------------------------------------------
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // -------------------------------------------------------------------------
  // Format classification. Compressed/reserved encodings (IR[1:0] != 2'b11)
  // are rejected regardless of the remaining opcode bits.
  // -------------------------------------------------------------------------
  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OP_LOAD, OP_OP_IMM, OP_JALR, OP_MISC_MEM, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                                            fmt = FMT_S;
      OP_BRANCH:                                           fmt = FMT_B;
      OP_LUI, OP_AUIPC:                                    fmt = FMT_U;
      OP_JAL:                                              fmt = FMT_J;
      OP_OP:                                               fmt = FMT_R;
      default:                                             fmt = FMT_BAD;
    endcase
    if (ir_q[1:0] != 2'b11) fmt = FMT_BAD;
  end

  // illegal is informational only; the bundle still handshakes and the
  // execute stage decides whether to trap.
  assign illegal = (fmt == FMT_BAD);

  // -------------------------------------------------------------------------
  // Immediate assembly. All sign extension comes from IR[31]; shift-immediate
  // encodings are passed through as ordinary I-type fields.
  // -------------------------------------------------------------------------
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{ir_q[31]}}, ir_q[31:20]};
      FMT_S: imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      FMT_B: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                    ir_q[11:8], 1'b0};
      FMT_U: imm = {ir_q[31:12], 12'b0};
      FMT_J: imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                    ir_q[30:21], 1'b0};
      default: imm = '0;  // R-type and illegal encodings
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage: a table of hand-decoded instructions,
// hand-written sequences for operand timing, backpressure, flush and reset,
// then randomized instructions compared against an arithmetic reference
// model of the RV32I field/immediate rules. A small register-file array
// supplies rs1v/rs2v combinationally.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b0;
  logic        instr_valid = 1'b0;
  logic        flush       = 1'b0;
  logic        dec_ready   = 1'b0;
  logic [31:0] instr       = '0;
  logic [31:0] pc          = '0;

  logic        instr_ready, dec_valid, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm, a_val, b_val, pc_q, rs1v, rs2v;

  logic [31:0] rf [32];
  assign rs1v = rf[rs1];
  assign rs2v = rf[rs2];

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .flush       (flush),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .rs1v        (rs1v),
    .rs2v        (rs2v),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .imm         (imm),
    .a_val       (a_val),
    .b_val       (b_val),
    .pc_q        (pc_q),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } vec_t;

  task automatic check_fields(input string tag, input vec_t v);
    check({tag, ".rs1"},     32'(rs1),     32'(v.rs1));
    check({tag, ".rs2"},     32'(rs2),     32'(v.rs2));
    check({tag, ".rd"},      32'(rd),      32'(v.rd));
    check({tag, ".opcode"},  32'(opcode),  32'(v.opcode));
    check({tag, ".funct3"},  32'(funct3),  32'(v.funct3));
    check({tag, ".funct7"},  32'(funct7),  32'(v.funct7));
    check({tag, ".imm"},     imm,          v.imm);
    check({tag, ".illegal"}, 32'(illegal), 32'(v.illegal));
    check({tag, ".pc_q"},    pc_q,         v.pc);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: field/immediate rules as plain arithmetic
  // -------------------------------------------------------------------------
  logic [6:0] i_ops [5]   = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73};
  logic [6:0] u_ops [2]   = '{7'h37, 7'h17};
  logic [6:0] all_ops [11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                               7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  function automatic bit in_list5(input logic [6:0] op);
    foreach (i_ops[i]) if (i_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_all(input logic [6:0] op);
    foreach (all_ops[i]) if (all_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic vec_t model(input logic [31:0] ins, input logic [31:0] p);
    vec_t   v;
    longint u    = longint'(ins);
    longint sgn  = (u >> 31) & 1;
    longint op   = u & 127;
    longint f    = 0;
    v.instr   = ins;
    v.pc      = p;
    v.rs1     = 5'((u >> 15) & 31);
    v.rs2     = 5'((u >> 20) & 31);
    v.rd      = 5'((u >> 7) & 31);
    v.opcode  = 7'(op);
    v.funct3  = 3'((u >> 12) & 7);
    v.funct7  = 7'((u >> 25) & 127);
    v.illegal = !(in_all(7'(op)) && ((u & 3) == 3));
    if (v.illegal)                 f = 0;
    else if (in_list5(7'(op)))     f = (u >> 20) - sgn * 4096;
    else if (op == 'h23)           f = ((u >> 25) << 5) + ((u >> 7) & 31) - sgn * 4096;
    else if (op == 'h63)           f = (sgn << 12) + (((u >> 7) & 1) << 11)
                                     + (((u >> 25) & 63) << 5) + (((u >> 8) & 15) << 1)
                                     - sgn * 8192;
    else if (op == longint'(u_ops[0]) || op == longint'(u_ops[1]))
                                   f = (u >> 12) << 12;
    else if (op == 'h6F)           f = (sgn << 20) + (((u >> 12) & 255) << 12)
                                     + (((u >> 20) & 1) << 11) + (((u >> 21) & 1023) << 1)
                                     - sgn * 2097152;
    else                           f = 0;
    v.imm = 32'(f);
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus helpers (all drive on the falling edge, sample on the falling edge)
  // -------------------------------------------------------------------------
  task automatic scramble_rf();
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;
  endtask

  // Ends at the falling edge inside READ.
  task automatic accept(input logic [31:0] ins, input logic [31:0] p);
    @(negedge clk);
    check("accept.instr_ready", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = ins;
    pc          = p;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom;
    pc          = $urandom;
  endtask

  // From the falling edge in READ to the falling edge of the first HOLD cycle.
  task automatic to_hold();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_bundle(input string tag);
    dec_ready   = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dec_ready = 1'b0;
    check({tag, ".idle.instr_ready"}, 32'(instr_ready), 32'd1);
    check({tag, ".idle.dec_valid"},   32'(dec_valid),   32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Test
  // -------------------------------------------------------------------------
  vec_t        vecs [10];
  vec_t        v;
  logic [31:0] exp_a, exp_b, r;

  initial begin
    vecs[0] = '{instr:32'h02A00293, pc:32'h100, rs1:5'd0,  rs2:5'd10, rd:5'd5,
                opcode:7'h13, funct3:3'd0, funct7:7'h01, imm:32'h0000002A, illegal:1'b0};
    vecs[1] = '{instr:32'hFE208CE3, pc:32'h104, rs1:5'd1,  rs2:5'd2,  rd:5'd25,
                opcode:7'h63, funct3:3'd0, funct7:7'h7F, imm:32'hFFFFFFF8, illegal:1'b0};
    vecs[2] = '{instr:32'h12345037, pc:32'h108, rs1:5'd8,  rs2:5'd3,  rd:5'd0,
                opcode:7'h37, funct3:3'd5, funct7:7'h09, imm:32'h12345000, illegal:1'b0};
    vecs[3] = '{instr:32'h002081B3, pc:32'h10C, rs1:5'd1,  rs2:5'd2,  rd:5'd3,
                opcode:7'h33, funct3:3'd0, funct7:7'h00, imm:32'h00000000, illegal:1'b0};
    vecs[4] = '{instr:32'hFE512E23, pc:32'h110, rs1:5'd2,  rs2:5'd5,  rd:5'd28,
                opcode:7'h23, funct3:3'd2, funct7:7'h7F, imm:32'hFFFFFFFC, illegal:1'b0};
    vecs[5] = '{instr:32'h001000EF, pc:32'h114, rs1:5'd0,  rs2:5'd1,  rd:5'd1,
                opcode:7'h6F, funct3:3'd0, funct7:7'h00, imm:32'h00000800, illegal:1'b0};
    vecs[6] = '{instr:32'hFFFFF297, pc:32'h118, rs1:5'd31, rs2:5'd31, rd:5'd5,
                opcode:7'h17, funct3:3'd7, funct7:7'h7F, imm:32'hFFFFF000, illegal:1'b0};
    vecs[7] = '{instr:32'hFFF00093, pc:32'h11C, rs1:5'd0,  rs2:5'd31, rd:5'd1,
                opcode:7'h13, funct3:3'd0, funct7:7'h7F, imm:32'hFFFFFFFF, illegal:1'b0};
    vecs[8] = '{instr:32'hFFFFFFFF, pc:32'h120, rs1:5'd31, rs2:5'd31, rd:5'd31,
                opcode:7'h7F, funct3:3'd7, funct7:7'h7F, imm:32'h00000000, illegal:1'b1};
    vecs[9] = '{instr:32'h00000000, pc:32'h124, rs1:5'd0,  rs2:5'd0,  rd:5'd0,
                opcode:7'h00, funct3:3'd0, funct7:7'h00, imm:32'h00000000, illegal:1'b1};

    for (int i = 0; i < 32; i++) rf[i] = '0;

    // ---- reset values ----------------------------------------------------
    #12;
    check("rst.instr_ready", 32'(instr_ready), 32'd1);
    check("rst.dec_valid",   32'(dec_valid),   32'd0);
    check("rst.illegal",     32'(illegal),     32'd0);
    check("rst.imm",         imm,              32'd0);
    check("rst.opcode",      32'(opcode),      32'h13);
    check("rst.pc_q",        pc_q,             32'd0);
    check("rst.a_val",       a_val,            32'd0);
    check("rst.b_val",       b_val,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- flush in IDLE blocks the accept ---------------------------------
    @(negedge clk);
    instr_valid = 1'b1;
    flush       = 1'b1;
    instr       = 32'hFFFFFFFF;
    pc          = 32'hDEAD0000;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    flush       = 1'b0;
    check("idle_flush.instr_ready", 32'(instr_ready), 32'd1);
    check("idle_flush.opcode",      32'(opcode),      32'h13);
    check("idle_flush.pc_q",        pc_q,             32'd0);

    // ---- table of decoded instructions -----------------------------------
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      scramble_rf();
      accept(vecs[i].instr, vecs[i].pc);
      check({tag, ".read.dec_valid"},   32'(dec_valid),   32'd0);
      check({tag, ".read.instr_ready"}, 32'(instr_ready), 32'd0);
      check_fields({tag, ".read"}, vecs[i]);
      exp_a = rf[vecs[i].rs1];
      exp_b = rf[vecs[i].rs2];
      to_hold();
      check({tag, ".hold.dec_valid"}, 32'(dec_valid), 32'd1);
      check_fields({tag, ".hold"}, vecs[i]);
      check({tag, ".a_val"}, a_val, exp_a);
      check({tag, ".b_val"}, b_val, exp_b);
      release_bundle(tag);
    end

    // ---- operand capture with a falling-edge write inside READ -----------
    rf[1] = 32'h11;
    rf[2] = 32'h22;
    accept(32'h002081B3, 32'h200);
    rf[2] = 32'h99;             // commits on the falling edge inside READ
    to_hold();
    check("opcap.a_val", a_val, 32'h11);
    check("opcap.b_val", b_val, 32'h99);
    rf[1] = 32'h55;             // after sampling: must not be reflected
    @(posedge clk);
    @(negedge clk);
    check("opcap.late.a_val",    a_val,           32'h11);
    check("opcap.late.dec_valid", 32'(dec_valid), 32'd1);
    release_bundle("opcap");

    // ---- backpressure: 3 stalled HOLD cycles with noisy inputs -----------
    scramble_rf();
    accept(32'h12345037, 32'h300);
    exp_a = rf[8];
    exp_b = rf[3];
    to_hold();
    for (int k = 0; k < 3; k++) begin
      instr_valid = 1'b1;
      instr       = $urandom;
      pc          = $urandom;
      scramble_rf();
      @(posedge clk);
      @(negedge clk);
      check("bp.dec_valid",   32'(dec_valid),   32'd1);
      check("bp.instr_ready", 32'(instr_ready), 32'd0);
      check_fields("bp", vecs[2].instr == 32'h12345037 ?
                   '{instr:32'h12345037, pc:32'h300, rs1:5'd8, rs2:5'd3, rd:5'd0,
                     opcode:7'h37, funct3:3'd5, funct7:7'h09, imm:32'h12345000,
                     illegal:1'b0} : vecs[2]);
      check("bp.a_val", a_val, exp_a);
      check("bp.b_val", b_val, exp_b);
    end
    release_bundle("bp");

    // ---- flush during READ: no operand capture, dec_valid never rises ----
    accept(32'h02A00293, 32'h400);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_read.instr_ready", 32'(instr_ready), 32'd1);
    check("flush_read.dec_valid",   32'(dec_valid),   32'd0);
    check("flush_read.a_val",       a_val,            exp_a);
    check("flush_read.b_val",       b_val,            exp_b);
    check("flush_read.opcode",      32'(opcode),      32'h13);
    check("flush_read.pc_q",        pc_q,             32'h400);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("flush_read.quiet.dec_valid", 32'(dec_valid), 32'd0);
    end

    // ---- flush in HOLD, alone and together with dec_ready ----------------
    for (int k = 0; k < 2; k++) begin
      accept(32'hFE208CE3, 32'h500);
      to_hold();
      flush     = 1'b1;
      dec_ready = (k == 1);
      @(posedge clk);
      @(negedge clk);
      flush     = 1'b0;
      dec_ready = 1'b0;
      check("flush_hold.instr_ready", 32'(instr_ready), 32'd1);
      check("flush_hold.dec_valid",   32'(dec_valid),   32'd0);
      check("flush_hold.imm",         imm,              32'hFFFFFFF8);
    end

    // ---- asynchronous reset in the middle of HOLD ------------------------
    scramble_rf();
    accept(32'hFE208CE3, 32'h600);
    to_hold();
    check("rst_hold.pre.dec_valid", 32'(dec_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold.dec_valid",   32'(dec_valid),   32'd0);
    check("rst_hold.instr_ready", 32'(instr_ready), 32'd1);
    check("rst_hold.ir_opcode",   32'(opcode),      32'h13);
    check("rst_hold.rs1",         32'(rs1),         32'd0);
    check("rst_hold.imm",         imm,              32'd0);
    check("rst_hold.pc_q",        pc_q,             32'd0);
    check("rst_hold.a_val",       a_val,            32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- randomized instructions against the reference model -----------
    for (int n = 0; n < 60; n++) begin
      logic [6:0]  op;
      logic [31:0] ins;
      int          stall;
      r  = $urandom;
      op = all_ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) op = r[6:0];
      ins = {r[31:7], op};
      v   = model(ins, $urandom);
      scramble_rf();
      accept(v.instr, v.pc);
      check("rnd.read.dec_valid", 32'(dec_valid), 32'd0);
      check_fields("rnd.read", v);
      if ($urandom_range(0, 1) == 1 && v.rs2 != 5'd0) rf[v.rs2] = $urandom;
      exp_a = rf[v.rs1];
      exp_b = rf[v.rs2];
      to_hold();
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        scramble_rf();
        @(posedge clk);
        @(negedge clk);
      end
      check("rnd.hold.dec_valid", 32'(dec_valid), 32'd1);
      check_fields("rnd.hold", v);
      check("rnd.a_val", a_val, exp_a);
      check("rnd.b_val", b_val, exp_b);
      release_bundle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
